// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the MEM pipeline stage.
package mem_stage_pkg;

  localparam int EX_MEM_BUS_W = 45;
  localparam int MEM_RF_BUS_W = 40;
  localparam int EXCEPT_BUS_W = 86;
  localparam int FWD_BUS_W    = 39;

  // Bit positions inside the one-hot ld_op field.
  localparam int LD_B  = 4;
  localparam int LD_H  = 3;
  localparam int LD_W  = 2;
  localparam int LD_BU = 1;
  localparam int LD_HU = 0;

  typedef struct packed {
    logic [4:0]  ld_op;
    logic        mem_req;
    logic        csr_re;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
  } ex_mem_bus_t;

  typedef struct packed {
    logic        ale;
    logic        adef;
    logic        ine;
    logic        intr;
    logic        brk;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        syscall;
    logic        ertn;
    logic        csr_we;
  } except_bus_t;

  // True when the instruction carries any exception (ertn is not an exception).
  function automatic logic exc_any(input except_bus_t e);
    return e.ale | e.adef | e.ine | e.intr | e.brk | e.syscall;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects and extends the addressed byte/halfword of a load response.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [4:0]  ld_op_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select by address offset, then sign/zero extension by load type.
  always_comb begin
    byte_sel = rdata_i[7:0];
    unique case (offset_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    data_o = 32'h0;
    if (ld_op_i[LD_B]) begin
      data_o = {{24{byte_sel[7]}}, byte_sel};
    end else if (ld_op_i[LD_BU]) begin
      data_o = {24'h0, byte_sel};
    end else if (ld_op_i[LD_H]) begin
      data_o = {{16{half_sel[15]}}, half_sel};
    end else if (ld_op_i[LD_HU]) begin
      data_o = {16'h0, half_sel};
    end else if (ld_op_i[LD_W]) begin
      data_o = rdata_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: latches EX results, waits for the data-SRAM response,
// aligns load data and presents WB / forwarding / exception buses.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    EX_MEM_valid,
  output logic                    MEM_allowin,
  input  logic [EX_MEM_BUS_W-1:0] EX_MEM_bus,
  input  logic [31:0]             EX_pc,
  input  logic [EXCEPT_BUS_W-1:0] EX_except_bus,
  input  logic                    data_sram_data_ok,
  input  logic [31:0]             data_sram_rdata,
  input  logic                    WB_allowin,
  input  logic                    flush,
  output logic                    MEM_WB_valid,
  output logic [MEM_RF_BUS_W-1:0] MEM_rf_bus,
  output logic [31:0]             MEM_pc,
  output logic [31:0]             MEM_alu_result,
  output logic [EXCEPT_BUS_W-1:0] MEM_except_bus,
  output logic [FWD_BUS_W-1:0]    MEM_fwd_bus,
  output logic                    MEM_exc_ertn
);

  logic        valid_q, valid_d;
  ex_mem_bus_t ex_q, ex_d;
  logic [31:0] pc_q, pc_d;
  except_bus_t exc_q, exc_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;
  logic        rdata_buf_vld_q, rdata_buf_vld_d;
  logic        discard_q, discard_d;

  logic        exc_hit;
  logic        mem_req_eff;
  logic        data_ok_now;
  logic        ready_go;
  logic        res_from_mem;
  logic        accept;
  logic        handoff;
  logic        in_wait;
  logic        ld_wait;
  logic [31:0] rdata_sel;
  logic [31:0] ld_data;
  logic [31:0] rf_wdata;

  // Handshake and response bookkeeping; a faulting instruction never waits on memory.
  always_comb begin
    exc_hit      = exc_any(exc_q);
    mem_req_eff  = ex_q.mem_req & ~exc_hit;
    data_ok_now  = data_sram_data_ok & ~discard_q;
    ready_go     = ~mem_req_eff | rdata_buf_vld_q | data_ok_now;
    res_from_mem = |ex_q.ld_op;
    MEM_allowin  = ~valid_q | (ready_go & WB_allowin);
    accept       = EX_MEM_valid & MEM_allowin;
    MEM_WB_valid = valid_q & ready_go & ~flush;
    handoff      = MEM_WB_valid & WB_allowin;
    in_wait      = valid_q & mem_req_eff & ~rdata_buf_vld_q & ~data_ok_now;
    ld_wait      = valid_q & res_from_mem & ~ready_go;
    rdata_sel    = rdata_buf_vld_q ? rdata_buf_q : data_sram_rdata;
  end

  mem_stage_load_align u_load_align (
    .ld_op_i  (ex_q.ld_op),
    .offset_i (ex_q.alu_result[1:0]),
    .rdata_i  (rdata_sel),
    .data_o   (ld_data)
  );

  // Output bus assembly from the latched payload.
  always_comb begin
    rf_wdata       = res_from_mem ? ld_data : ex_q.alu_result;
    MEM_rf_bus     = {res_from_mem, ex_q.csr_re, ex_q.rf_we, ex_q.rf_waddr, rf_wdata};
    MEM_fwd_bus    = {valid_q & ex_q.rf_we, ld_wait, ex_q.rf_waddr, rf_wdata};
    MEM_pc         = pc_q;
    MEM_alu_result = ex_q.alu_result;
    MEM_except_bus = exc_q;
    MEM_exc_ertn   = valid_q & (exc_hit | exc_q.ertn);
  end

  // Next-state: flush beats accept; a flushed in-flight request leaves one response to drop.
  always_comb begin
    valid_d         = valid_q;
    ex_d            = ex_q;
    pc_d            = pc_q;
    exc_d           = exc_q;
    rdata_buf_d     = rdata_buf_q;
    rdata_buf_vld_d = rdata_buf_vld_q;
    discard_d       = discard_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (MEM_allowin) begin
      valid_d = EX_MEM_valid;
    end

    if (accept && !flush) begin
      ex_d  = EX_MEM_bus;
      pc_d  = EX_pc;
      exc_d = EX_except_bus;
    end

    if (flush || handoff) begin
      rdata_buf_vld_d = 1'b0;
    end else if (valid_q && mem_req_eff && data_ok_now && !WB_allowin) begin
      rdata_buf_d     = data_sram_rdata;
      rdata_buf_vld_d = 1'b1;
    end

    if (discard_q && data_sram_data_ok) begin
      discard_d = 1'b0;
    end
    if (flush && in_wait) begin
      discard_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q         <= 1'b0;
      ex_q            <= '0;
      pc_q            <= 32'h0;
      exc_q           <= '0;
      rdata_buf_q     <= 32'h0;
      rdata_buf_vld_q <= 1'b0;
      discard_q       <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      ex_q            <= ex_d;
      pc_q            <= pc_d;
      exc_q           <= exc_d;
      rdata_buf_q     <= rdata_buf_d;
      rdata_buf_vld_q <= rdata_buf_vld_d;
      discard_q       <= discard_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB payloads are queued at issue
// and compared when the stage hands an instruction to WB.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        EX_MEM_valid;
  logic        MEM_allowin;
  logic [44:0] EX_MEM_bus;
  logic [31:0] EX_pc;
  logic [85:0] EX_except_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        WB_allowin;
  logic        flush;
  logic        MEM_WB_valid;
  logic [39:0] MEM_rf_bus;
  logic [31:0] MEM_pc;
  logic [31:0] MEM_alu_result;
  logic [85:0] MEM_except_bus;
  logic [38:0] MEM_fwd_bus;
  logic        MEM_exc_ertn;

  typedef struct {
    logic [39:0] rf;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .EX_MEM_valid      (EX_MEM_valid),
    .MEM_allowin       (MEM_allowin),
    .EX_MEM_bus        (EX_MEM_bus),
    .EX_pc             (EX_pc),
    .EX_except_bus     (EX_except_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .WB_allowin        (WB_allowin),
    .flush             (flush),
    .MEM_WB_valid      (MEM_WB_valid),
    .MEM_rf_bus        (MEM_rf_bus),
    .MEM_pc            (MEM_pc),
    .MEM_alu_result    (MEM_alu_result),
    .MEM_except_bus    (MEM_except_bus),
    .MEM_fwd_bus       (MEM_fwd_bus),
    .MEM_exc_ertn      (MEM_exc_ertn)
  );

  always #5 clk = ~clk;

  // Reference load extension: shift the addressed lane down, then extend.
  function automatic logic [31:0] ref_load(input logic [4:0] ld, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * off);
    case (ld)
      5'b10000: return {{24{sh[7]}}, sh[7:0]};
      5'b00010: return {24'h0, sh[7:0]};
      5'b01000: return {{16{sh[15]}}, sh[15:0]};
      5'b00001: return {16'h0, sh[15:0]};
      default:  return rd;
    endcase
  endfunction

  // Scoreboard monitor: every handoff to WB must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && MEM_WB_valid === 1'b1 && WB_allowin === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: handoff rf_bus=%h pc=%h with nothing expected", MEM_rf_bus, MEM_pc);
      end else begin
        mon_e = sb.pop_front();
        if (MEM_rf_bus !== mon_e.rf || MEM_pc !== mon_e.pc) begin
          failures++;
          $display("FAIL sb_handoff: got rf_bus=%h pc=%h want rf_bus=%h pc=%h",
                   MEM_rf_bus, MEM_pc, mon_e.rf, mon_e.pc);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [4:0] ld, input logic req, input logic we,
                          input logic [4:0] wa, input logic [31:0] alu, input logic [31:0] pc);
    EX_MEM_valid = 1'b1;
    EX_MEM_bus   = {ld, req, 1'b0, we, wa, alu};
    EX_pc        = pc;
  endtask

  task automatic push_exp(input logic res, input logic we, input logic [4:0] wa,
                          input logic [31:0] wdata, input logic [31:0] pc);
    exp_t e;
    e.rf = {res, 1'b0, we, wa, wdata};
    e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    EX_MEM_valid = 1'b0; EX_MEM_bus = '0; EX_pc = '0; EX_except_bus = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; WB_allowin = 1'b1; flush = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    checks++;
    if ({MEM_WB_valid, MEM_rf_bus, MEM_pc, MEM_alu_result, MEM_except_bus, MEM_fwd_bus, MEM_exc_ertn} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got wbv=%b rf=%h pc=%h fwd=%h want all zero",
               MEM_WB_valid, MEM_rf_bus, MEM_pc, MEM_fwd_bus);
    end
    checks++;
    if (MEM_allowin !== 1'b1) begin
      failures++;
      $display("FAIL reset_allowin: got %b want 1", MEM_allowin);
    end
    cyc();
    resetn = 1'b1;
  endtask

  task automatic test_add();
    cyc();
    drive_ex(5'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h1c00_0000);
    push_exp(1'b0, 1'b1, 5'd5, 32'h1234, 32'h1c00_0000);
    cyc();
    EX_MEM_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (MEM_WB_valid !== 1'b1) begin
      failures++;
      $display("FAIL add_wbvalid: got %b want 1", MEM_WB_valid);
    end
    checks++;
    if (MEM_fwd_bus !== {1'b1, 1'b0, 5'd5, 32'h1234}) begin
      failures++;
      $display("FAIL add_fwd: got %h want %h", MEM_fwd_bus, {1'b1, 1'b0, 5'd5, 32'h1234});
    end
    cyc();
    @(negedge clk);
    checks++;
    if (MEM_WB_valid !== 1'b0) begin
      failures++;
      $display("FAIL add_drain: got %b want 0", MEM_WB_valid);
    end
  endtask

  task automatic test_ld_b_wait();
    cyc();
    drive_ex(5'b10000, 1'b1, 1'b1, 5'd7, 32'h1000_0003, 32'h1c00_0010);
    push_exp(1'b1, 1'b1, 5'd7, 32'hFFFF_FF80, 32'h1c00_0010);
    for (int k = 0; k < 2; k++) begin
      cyc();
      EX_MEM_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({MEM_allowin, MEM_fwd_bus[37], MEM_WB_valid} !== 3'b010) begin
        failures++;
        $display("FAIL ldb_wait: got allowin=%b ld_wait=%b wbv=%b want 0 1 0",
                 MEM_allowin, MEM_fwd_bus[37], MEM_WB_valid);
      end
    end
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_0000;
    @(negedge clk);
    checks++;
    if ({MEM_allowin, MEM_fwd_bus[37]} !== 2'b10) begin
      failures++;
      $display("FAIL ldb_release: got allowin=%b ld_wait=%b want 1 0", MEM_allowin, MEM_fwd_bus[37]);
    end
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
  endtask

  task automatic test_ld_hu_buffer();
    cyc();
    drive_ex(5'b00001, 1'b1, 1'b1, 5'd8, 32'h2000_0002, 32'h1c00_0020);
    push_exp(1'b1, 1'b1, 5'd8, 32'h0000_BEEF, 32'h1c00_0020);
    cyc();
    EX_MEM_valid = 1'b0;
    WB_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF_1111;
    @(negedge clk);
    checks++;
    if ({MEM_WB_valid, MEM_allowin} !== 2'b10) begin
      failures++;
      $display("FAIL hu_ok_stalled: got wbv=%b allowin=%b want 1 0", MEM_WB_valid, MEM_allowin);
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'hDEAD_DEAD;
      @(negedge clk);
      checks++;
      if (MEM_rf_bus[31:0] !== 32'h0000_BEEF || MEM_WB_valid !== 1'b1) begin
        failures++;
        $display("FAIL hu_buffered: got wdata=%h wbv=%b want 0000beef 1", MEM_rf_bus[31:0], MEM_WB_valid);
      end
    end
    cyc();
    WB_allowin = 1'b1;
    cyc();
    data_sram_rdata = '0;
    @(negedge clk);
    checks++;
    if (MEM_WB_valid !== 1'b0) begin
      failures++;
      $display("FAIL hu_drain: got %b want 0", MEM_WB_valid);
    end
  endtask

  task automatic test_flush_discard();
    cyc();
    drive_ex(5'b00100, 1'b1, 1'b1, 5'd3, 32'h3000_0000, 32'h1c00_0030);
    cyc();
    EX_MEM_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    checks++;
    if (MEM_WB_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_wbvalid: got %b want 0", MEM_WB_valid);
    end
    cyc();
    flush = 1'b0;
    drive_ex(5'b00100, 1'b1, 1'b1, 5'd4, 32'h3000_0004, 32'h1c00_0034);
    push_exp(1'b1, 1'b1, 5'd4, 32'h0000_0005, 32'h1c00_0034);
    @(negedge clk);
    checks++;
    if (MEM_allowin !== 1'b1) begin
      failures++;
      $display("FAIL flush_empty: got allowin=%b want 1", MEM_allowin);
    end
    cyc();
    EX_MEM_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAAAA_AAAA;
    @(negedge clk);
    checks++;
    if ({MEM_WB_valid, MEM_fwd_bus[37]} !== 2'b01) begin
      failures++;
      $display("FAIL flush_stale_dropped: got wbv=%b ld_wait=%b want 0 1", MEM_WB_valid, MEM_fwd_bus[37]);
    end
    cyc();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    checks++;
    if (MEM_fwd_bus[37] !== 1'b1) begin
      failures++;
      $display("FAIL flush_still_wait: got ld_wait=%b want 1", MEM_fwd_bus[37]);
    end
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0005;
    @(negedge clk);
    checks++;
    if (MEM_WB_valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_own_ok: got wbv=%b want 1", MEM_WB_valid);
    end
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
  endtask

  task automatic test_flush_with_ok();
    cyc();
    drive_ex(5'b00100, 1'b1, 1'b1, 5'd6, 32'h3100_0000, 32'h1c00_0040);
    cyc();
    EX_MEM_valid = 1'b0;
    flush = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    cyc();
    flush = 1'b0;
    data_sram_data_ok = 1'b0;
    drive_ex(5'b00100, 1'b1, 1'b1, 5'd6, 32'h3100_0004, 32'h1c00_0044);
    push_exp(1'b1, 1'b1, 5'd6, 32'h0000_0066, 32'h1c00_0044);
    cyc();
    EX_MEM_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0066;
    @(negedge clk);
    checks++;
    if (MEM_WB_valid !== 1'b1) begin
      failures++;
      $display("FAIL flushok_not_discarded: got wbv=%b want 1", MEM_WB_valid);
    end
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
  endtask

  task automatic test_exception();
    logic [85:0] exc_v;
    exc_v = {5'b00000, 14'h0005, 32'hFFFF_0000, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
    cyc();
    drive_ex(5'b0, 1'b1, 1'b0, 5'd2, 32'h0000_0040, 32'h1c00_0050);
    EX_except_bus = exc_v;
    push_exp(1'b0, 1'b0, 5'd2, 32'h0000_0040, 32'h1c00_0050);
    cyc();
    EX_MEM_valid = 1'b0;
    EX_except_bus = '0;
    @(negedge clk);
    checks++;
    if ({MEM_WB_valid, MEM_exc_ertn} !== 2'b11) begin
      failures++;
      $display("FAIL exc_flags: got wbv=%b exc_ertn=%b want 1 1", MEM_WB_valid, MEM_exc_ertn);
    end
    checks++;
    if (MEM_except_bus !== exc_v || MEM_alu_result !== 32'h0000_0040) begin
      failures++;
      $display("FAIL exc_bus: got exc=%h vaddr=%h want exc=%h vaddr=00000040",
               MEM_except_bus, MEM_alu_result, exc_v);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (MEM_exc_ertn !== 1'b0) begin
      failures++;
      $display("FAIL exc_drain: got %b want 0", MEM_exc_ertn);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops [5];
    logic [4:0]  ld;
    logic [1:0]  off;
    logic [31:0] rd [8];
    int          sel;
    ops[0] = 5'b10000; ops[1] = 5'b01000; ops[2] = 5'b00100; ops[3] = 5'b00010; ops[4] = 5'b00001;
    for (int i = 0; i <= 8; i++) begin
      cyc();
      if (i < 8) begin
        sel = (i < 5) ? i : int'($urandom_range(0, 4));
        ld  = ops[sel];
        off = 2'(i);
        if (ld == 5'b00100) off = 2'd0;
        if (ld == 5'b01000 || ld == 5'b00001) off = {off[1], 1'b0};
        rd[i] = (i == 0) ? 32'h0000_8000 : $urandom();
        if (i == 1) rd[i] = 32'h0000_9ABC;
        drive_ex(ld, 1'b1, 1'b1, 5'(i + 10), {28'h700_0000, 2'b00, off}, 32'h1c00_0100 + 32'(4 * i));
        push_exp(1'b1, 1'b1, 5'(i + 10), ref_load(ld, off, rd[i]), 32'h1c00_0100 + 32'(4 * i));
      end else begin
        EX_MEM_valid = 1'b0;
      end
      if (i > 0) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd[i - 1];
      end else begin
        data_sram_data_ok = 1'b0;
      end
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (MEM_WB_valid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_wbvalid[%0d]: got %b want 1", i, MEM_WB_valid);
        end
      end
    end
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
  endtask

  task automatic test_reset_wait();
    cyc();
    drive_ex(5'b00100, 1'b1, 1'b1, 5'd10, 32'h5000_0000, 32'h1c00_0200);
    cyc();
    EX_MEM_valid = 1'b0;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    drive_ex(5'b00100, 1'b1, 1'b1, 5'd11, 32'h5000_0004, 32'h1c00_0204);
    cyc();
    EX_MEM_valid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (MEM_fwd_bus[37] !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_wait: got ld_wait=%b want 1", MEM_fwd_bus[37]);
    end
    cyc();
    resetn = 1'b1;
    drive_ex(5'b00100, 1'b1, 1'b1, 5'd9, 32'h6000_0000, 32'h1c00_0300);
    push_exp(1'b1, 1'b1, 5'd9, 32'h0000_0077, 32'h1c00_0300);
    @(negedge clk);
    checks++;
    if ({MEM_WB_valid, MEM_rf_bus, MEM_pc, MEM_alu_result, MEM_except_bus, MEM_fwd_bus, MEM_exc_ertn} !== '0
        || MEM_allowin !== 1'b1) begin
      failures++;
      $display("FAIL rst_outputs: got wbv=%b rf=%h pc=%h fwd=%h allowin=%b want zeros allowin=1",
               MEM_WB_valid, MEM_rf_bus, MEM_pc, MEM_fwd_bus, MEM_allowin);
    end
    cyc();
    EX_MEM_valid = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0077;
    @(negedge clk);
    checks++;
    if (MEM_WB_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_discard_cleared: got wbv=%b want 1", MEM_WB_valid);
    end
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_ld_b_wait();
    test_ld_hu_buffer();
    test_flush_discard();
    test_flush_with_ok();
    test_exception();
    test_back_to_back();
    test_reset_wait();
    cyc();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
